// File: rtl/snn_pkg.sv
// Shared types and lane helpers for the SNN stimulus sequencer.
// A pattern word packs {ui_hi, ui_lo, uio_hi, uio_lo} as four intensity nibbles.
package snn_pkg;

   localparam int NIBBLE_W = 4;
   localparam int LANE_W   = 2 * NIBBLE_W;
   localparam int PAT_W    = 2 * LANE_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_REST    = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   function automatic logic [LANE_W-1:0] ui_lane(input logic [PAT_W-1:0] pat);
      return pat[PAT_W-1:LANE_W];
   endfunction

   function automatic logic [LANE_W-1:0] uio_lane(input logic [PAT_W-1:0] pat);
      return pat[LANE_W-1:0];
   endfunction

endpackage

// File: rtl/snn_stimulus_sequencer_if.sv
// Pattern load channel and result stream between the host and the sequencer.
interface snn_stimulus_sequencer_if #(
   parameter int DEPTH = 8
);
   import snn_pkg::*;

   logic                     wr_valid;
   logic [PAT_W-1:0]         wr_data;
   logic                     wr_ready;
   logic                     res_valid;
   logic [LANE_W-1:0]        res_data;
   logic [$clog2(DEPTH)-1:0] res_idx;

   modport master (
      output wr_valid, wr_data,
      input  wr_ready, res_valid, res_data, res_idx
   );

   modport slave (
      input  wr_valid, wr_data,
      output wr_ready, res_valid, res_data, res_idx
   );

endinterface

// File: rtl/snn_pattern_buf.sv
// DEPTH x 16 pattern register file, filled in order from slot 0, read asynchronously by index.
module snn_pattern_buf
   import snn_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [PAT_W-1:0]           wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [PAT_W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [PAT_W-1:0] mem_r [DEPTH];
   logic [CNT_W-1:0] count_r;

   // Fill level; clear wins over a same-cycle write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (wr_en) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   // Storage needs no reset: slots at or above count are never read.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         mem_r[count_r[IDX_W-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_idx];
   assign count   = count_r;
   assign full    = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/snn_stimulus_sequencer.sv
// Plays buffered input patterns onto the network lanes as hold/rest presentations
// and returns the network output byte captured at the end of every hold.
module snn_stimulus_sequencer
   import snn_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int HOLD_W = 8,
   parameter int REP_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              clr,
   input  logic              start,
   input  logic              abort,
   input  logic [HOLD_W-1:0] hold_len,
   input  logic [HOLD_W-1:0] rest_len,
   input  logic [REP_W-1:0]  repeat_cnt,
   input  logic [LANE_W-1:0] net_out,
   output logic [LANE_W-1:0] ui_drv,
   output logic [LANE_W-1:0] uio_drv,
   output logic              busy,
   output logic              done,
   snn_stimulus_sequencer_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   state_e            state_r;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  nxt_idx_s;
   logic [REP_W-1:0]  pass_r;
   logic [REP_W-1:0]  rep_r;
   logic [HOLD_W-1:0] hold_r;
   logic [HOLD_W-1:0] rest_r;
   logic [HOLD_W-1:0] cnt_r;
   logic [LANE_W-1:0] ui_r;
   logic [LANE_W-1:0] uio_r;
   logic [LANE_W-1:0] res_data_r;
   logic [IDX_W-1:0]  res_idx_r;
   logic              res_valid_r;
   logic              done_r;

   logic [CNT_W-1:0]  count_s;
   logic              full_s;
   logic [PAT_W-1:0]  rd_data_s;
   logic              idle_s;
   logic              wr_ready_s;
   logic [HOLD_W-1:0] hold_max_s;
   logic [REP_W-1:0]  rep_max_s;
   logic              seg_end_s;
   logic              last_idx_s;
   logic              last_pass_s;
   logic              adv_s;

   assign idle_s      = (state_r == ST_IDLE);
   assign wr_ready_s  = ena && idle_s && !full_s;
   assign hold_max_s  = (hold_len == {HOLD_W{1'b0}}) ? HOLD_W'(1) : hold_len;
   assign rep_max_s   = (repeat_cnt == {REP_W{1'b0}}) ? REP_W'(1) : repeat_cnt;
   assign seg_end_s   = (cnt_r <= HOLD_W'(1));
   assign last_idx_s  = ({1'b0, idx_r} == (count_s - CNT_W'(1)));
   assign last_pass_s = (pass_r == (rep_r - REP_W'(1)));
   assign adv_s       = seg_end_s && (((state_r == ST_PRESENT) && (rest_r == {HOLD_W{1'b0}}))
                                      || (state_r == ST_REST));

   // Index of the pattern to be driven next; also the buffer read address.
   always_comb begin
      nxt_idx_s = {IDX_W{1'b0}};
      if (idle_s || last_idx_s) begin
         nxt_idx_s = {IDX_W{1'b0}};
      end else begin
         nxt_idx_s = idx_r + IDX_W'(1);
      end
   end

   snn_pattern_buf #(.DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ena && idle_s && clr),
      .wr_en   (bus.wr_valid && wr_ready_s),
      .wr_data (bus.wr_data),
      .rd_idx  (nxt_idx_s),
      .rd_data (rd_data_s),
      .count   (count_s),
      .full    (full_s)
   );

   // Playback FSM with its counters, lane drives and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         idx_r       <= {IDX_W{1'b0}};
         pass_r      <= {REP_W{1'b0}};
         rep_r       <= {REP_W{1'b0}};
         hold_r      <= {HOLD_W{1'b0}};
         rest_r      <= {HOLD_W{1'b0}};
         cnt_r       <= {HOLD_W{1'b0}};
         ui_r        <= {LANE_W{1'b0}};
         uio_r       <= {LANE_W{1'b0}};
         res_data_r  <= {LANE_W{1'b0}};
         res_idx_r   <= {IDX_W{1'b0}};
         res_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else if (ena) begin
         res_valid_r <= 1'b0;
         done_r      <= 1'b0;
         if (!idle_s && abort) begin
            state_r <= ST_IDLE;
            ui_r    <= {LANE_W{1'b0}};
            uio_r   <= {LANE_W{1'b0}};
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start) begin
                     hold_r <= hold_max_s;
                     rest_r <= rest_len;
                     rep_r  <= rep_max_s;
                     pass_r <= {REP_W{1'b0}};
                     idx_r  <= {IDX_W{1'b0}};
                     if (count_s != {CNT_W{1'b0}}) begin
                        state_r <= ST_PRESENT;
                        cnt_r   <= hold_max_s;
                        ui_r    <= ui_lane(rd_data_s);
                        uio_r   <= uio_lane(rd_data_s);
                     end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                     end
                  end
               end
               ST_PRESENT: begin
                  if (!seg_end_s) begin
                     cnt_r <= cnt_r - HOLD_W'(1);
                  end else begin
                     res_valid_r <= 1'b1;
                     res_data_r  <= net_out;
                     res_idx_r   <= idx_r;
                     if (rest_r != {HOLD_W{1'b0}}) begin
                        state_r <= ST_REST;
                        cnt_r   <= rest_r;
                        ui_r    <= {LANE_W{1'b0}};
                        uio_r   <= {LANE_W{1'b0}};
                     end
                  end
               end
               ST_REST: begin
                  if (!seg_end_s) begin
                     cnt_r <= cnt_r - HOLD_W'(1);
                  end
               end
               ST_DONE: begin
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
                  ui_r    <= {LANE_W{1'b0}};
                  uio_r   <= {LANE_W{1'b0}};
               end
            endcase
            // End of a presentation: next pattern, next pass, or finish.
            if (adv_s) begin
               idx_r <= nxt_idx_s;
               if (last_idx_s) begin
                  pass_r <= pass_r + REP_W'(1);
               end
               if (last_idx_s && last_pass_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                  ui_r    <= {LANE_W{1'b0}};
                  uio_r   <= {LANE_W{1'b0}};
               end else begin
                  state_r <= ST_PRESENT;
                  cnt_r   <= hold_r;
                  ui_r    <= ui_lane(rd_data_s);
                  uio_r   <= uio_lane(rd_data_s);
               end
            end
         end
      end
   end

   assign ui_drv        = ui_r;
   assign uio_drv       = uio_r;
   assign busy          = !idle_s;
   assign done          = done_r;
   assign bus.wr_ready  = wr_ready_s;
   assign bus.res_valid = res_valid_r;
   assign bus.res_data  = res_data_r;
   assign bus.res_idx   = res_idx_r;

endmodule
